block_controller: RTL and testbench

BLOCK_CONTROLLER -- requirements
Module: block_controller

---
 rtl/block_controller.sv | 191 +++++++++++++++++++
 tb/tb_block_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_controller.sv
// block_controller: moves a 16x16 Pac-Man square around a walled playfield
// under button control, reports which one-pixel moves are legal, and colours
// the current VGA scan pixel.

module block_controller #(
    parameter int MOVE_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mastClk,
    input  logic        bright,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [11:0] rgb,
    output logic [11:0] background,
    output logic        leg_l,
    output logic        leg_r,
    output logic        leg_u,
    output logic        leg_d
);

    // Playfield geometry. All arithmetic is done in 12-bit signed so that a
    // one-pixel step off the left/top edge, or a scan position left of the
    // playfield origin, becomes negative rather than wrapping.
    localparam logic signed [11:0] PF_X0      = 12'sd144;
    localparam logic signed [11:0] PF_Y0      = 12'sd35;
    localparam logic signed [11:0] PF_W       = 12'sd640;
    localparam logic signed [11:0] PF_H       = 12'sd480;
    localparam logic signed [11:0] SPRITE     = 12'sd16;
    localparam logic signed [11:0] SPRITE_M1  = 12'sd15;
    localparam logic signed [11:0] ONE        = 12'sd1;
    localparam logic signed [11:0] ZERO       = 12'sd0;
    localparam logic signed [11:0] WALL_LO    = 12'sd16;
    localparam logic signed [11:0] WALL_X_HI  = 12'sd624;
    localparam logic signed [11:0] WALL_Y_HI  = 12'sd464;
    localparam logic signed [11:0] BLOCK_X0   = 12'sd160;
    localparam logic signed [11:0] BLOCK_X1   = 12'sd480;
    localparam logic signed [11:0] BLOCK_Y0   = 12'sd96;
    localparam logic signed [11:0] BLOCK_Y1   = 12'sd128;

    localparam logic [9:0] RESET_X = 10'd312;
    localparam logic [9:0] RESET_Y = 10'd232;

    localparam logic [11:0] COLOUR_BLACK  = 12'h000;
    localparam logic [11:0] COLOUR_PACMAN = 12'hFF0;
    localparam logic [11:0] COLOUR_WALL   = 12'h00F;

    // The move divider needs at least one bit even when MOVE_DIV is 1.
    localparam int                CNT_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MOVE_DIV - 1);

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    logic [9:0]         r_xpos;
    logic [9:0]         r_ypos;
    logic [CNT_W-1:0]   r_moveCnt;

    logic               w_moveTick;
    dir_t               w_dir;
    logic               w_dirLegal;
    logic signed [11:0] w_x;
    logic signed [11:0] w_y;
    logic signed [11:0] w_px;
    logic signed [11:0] w_py;
    logic               w_inPlayfield;
    logic               w_pacPixel;
    logic               w_wallPixel;
    logic               w_unusedMastClk;

    // mastClk is a reserved input with no function in this design.
    assign w_unusedMastClk = mastClk;

    // True when a 16x16 square with top-left (x, y) touches any wall pixel:
    // the 16-pixel border ring or the inner horizontal block.
    function automatic logic squareHitsWall(input logic signed [11:0] x,
                                            input logic signed [11:0] y);
        logic hitBorder;
        logic hitBlock;
        hitBorder = (x < WALL_LO) || ((x + SPRITE_M1) >= WALL_X_HI) ||
                    (y < WALL_LO) || ((y + SPRITE_M1) >= WALL_Y_HI);
        hitBlock  = ((x + SPRITE_M1) >= BLOCK_X0) && (x < BLOCK_X1) &&
                    ((y + SPRITE_M1) >= BLOCK_Y0) && (y < BLOCK_Y1);
        return hitBorder || hitBlock;
    endfunction

    // True when the single playfield pixel (x, y) is a wall pixel.
    function automatic logic pixelIsWall(input logic signed [11:0] x,
                                         input logic signed [11:0] y);
        logic isBorder;
        logic isBlock;
        isBorder = (x < WALL_LO) || (x >= WALL_X_HI) ||
                   (y < WALL_LO) || (y >= WALL_Y_HI);
        isBlock  = (x >= BLOCK_X0) && (x < BLOCK_X1) &&
                   (y >= BLOCK_Y0) && (y < BLOCK_Y1);
        return isBorder || isBlock;
    endfunction

    assign w_x = $signed({2'b00, r_xpos});
    assign w_y = $signed({2'b00, r_ypos});

    // Legal-move flags follow the current position within the same cycle.
    assign leg_l = !squareHitsWall(w_x - ONE, w_y);
    assign leg_r = !squareHitsWall(w_x + ONE, w_y);
    assign leg_u = !squareHitsWall(w_x, w_y - ONE);
    assign leg_d = !squareHitsWall(w_x, w_y + ONE);

    assign background = COLOUR_BLACK;

    assign w_moveTick = (r_moveCnt == CNT_MAX);

    // Pick the single highest-priority pressed button; lower-priority
    // buttons are ignored even when the chosen direction is blocked.
    always_comb begin
        w_dir      = DIR_NONE;
        w_dirLegal = 1'b0;
        if (up) begin
            w_dir      = DIR_UP;
            w_dirLegal = leg_u;
        end else if (down) begin
            w_dir      = DIR_DOWN;
            w_dirLegal = leg_d;
        end else if (left) begin
            w_dir      = DIR_LEFT;
            w_dirLegal = leg_l;
        end else if (right) begin
            w_dir      = DIR_RIGHT;
            w_dirLegal = leg_r;
        end
    end

    // Free-running move divider and the position registers, which step one
    // pixel on each divider wrap when the selected move is legal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xpos    <= RESET_X;
            r_ypos    <= RESET_Y;
            r_moveCnt <= '0;
        end else begin
            if (w_moveTick) begin
                r_moveCnt <= '0;
            end else begin
                r_moveCnt <= r_moveCnt + 1'b1;
            end

            if (w_moveTick && w_dirLegal) begin
                case (w_dir)
                    DIR_UP:    r_ypos <= r_ypos - 10'd1;
                    DIR_DOWN:  r_ypos <= r_ypos + 10'd1;
                    DIR_LEFT:  r_xpos <= r_xpos - 10'd1;
                    DIR_RIGHT: r_xpos <= r_xpos + 10'd1;
                    default:   ;
                endcase
            end
        end
    end

    // Translate the scan counters into playfield coordinates.
    assign w_px = $signed({2'b00, hCount}) - PF_X0;
    assign w_py = $signed({2'b00, vCount}) - PF_Y0;

    assign w_inPlayfield = (w_px >= ZERO) && (w_px < PF_W) &&
                           (w_py >= ZERO) && (w_py < PF_H);

    assign w_pacPixel = (w_px >= w_x) && (w_px < (w_x + SPRITE)) &&
                        (w_py >= w_y) && (w_py < (w_y + SPRITE));

    assign w_wallPixel = w_inPlayfield && pixelIsWall(w_px, w_py);

    // Pixel colour: blanking first, then Pac-Man, then walls, else background.
    always_comb begin
        rgb = background;
        if (!bright) begin
            rgb = COLOUR_BLACK;
        end else if (w_pacPixel) begin
            rgb = COLOUR_PACMAN;
        end else if (w_wallPixel) begin
            rgb = COLOUR_WALL;
        end
    end

endmodule

// File: tb/tb_block_controller.sv
// tb_block_controller: randomized and directed stimulus for block_controller,
// checked through a scoreboard queue against a pixel-level reference model.

module tb_block_controller;

   localparam int MOVE_DIV = 4;

   logic        clk = 1'b0;
   logic        mastClk = 1'b0;
   logic        rst;
   logic        bright;
   logic        up;
   logic        down;
   logic        left;
   logic        right;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic [11:0] rgb;
   logic [11:0] background;
   logic        leg_l;
   logic        leg_r;
   logic        leg_u;
   logic        leg_d;

   block_controller #(.MOVE_DIV(MOVE_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .mastClk    (mastClk),
      .bright     (bright),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .hCount     (hCount),
      .vCount     (vCount),
      .rgb        (rgb),
      .background (background),
      .leg_l      (leg_l),
      .leg_r      (leg_r),
      .leg_u      (leg_u),
      .leg_d      (leg_d)
   );

   // Main clock plus an unrelated toggle on the reserved input.
   always #5 clk = ~clk;
   always #7 mastClk = ~mastClk;

   typedef struct {
      int          x;
      int          y;
      logic [3:0]  legs;
      logic [11:0] rgb;
   } expT;

   expT sbQ[$];

   int nCompared   = 0;
   int nMismatched = 0;

   int mX;
   int mY;
   int mCycles;
   bit modelValid = 1'b0;

   // Reference model: a wall is judged pixel by pixel.
   function automatic bit isWall(input int a, input int b);
      if (a < 16 || a >= 624 || b < 16 || b >= 464) return 1'b1;
      if (a >= 160 && a < 480 && b >= 96 && b < 128) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: scan every pixel of the 16x16 square for a wall.
   function automatic bit squareHits(input int x, input int y);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            if (isWall(x + i, y + j)) return 1'b1;
      return 1'b0;
   endfunction

   // Legal moves packed as {left, right, up, down}.
   function automatic logic [3:0] modelLegs(input int x, input int y);
      return {!squareHits(x - 1, y), !squareHits(x + 1, y),
              !squareHits(x, y - 1), !squareHits(x, y + 1)};
   endfunction

   function automatic logic [11:0] modelRgb(input int x, input int y,
                                            input bit b, input int h, input int v);
      int px;
      int py;
      px = h - 144;
      py = v - 35;
      if (!b) return 12'h000;
      if (px >= x && px < x + 16 && py >= y && py < y + 16) return 12'hFF0;
      if (px >= 0 && px < 640 && py >= 0 && py < 480 && isWall(px, py)) return 12'h00F;
      return 12'h000;
   endfunction

   // Advance the model across one clock edge with the inputs held during it.
   function automatic void modelEdge(input bit iRst, input bit iUp, input bit iDown,
                                     input bit iLeft, input bit iRight);
      int dx;
      int dy;
      bit tick;
      if (iRst) begin
         mX = 312;
         mY = 232;
         mCycles = 0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         tick = ((mCycles % MOVE_DIV) == MOVE_DIV - 1);
         mCycles++;
         dx = 0;
         dy = 0;
         if (iUp) dy = -1;
         else if (iDown) dy = 1;
         else if (iLeft) dx = -1;
         else if (iRight) dx = 1;
         if (tick && (dx != 0 || dy != 0) && !squareHits(mX + dx, mY + dy)) begin
            mX += dx;
            mY += dy;
         end
      end
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, queue the expected outputs, cross one edge.
   task automatic applyStimulus(input bit iRst, input bit iUp, input bit iDown,
                                input bit iLeft, input bit iRight, input bit iBright,
                                input int h, input int v);
      expT e;
      rst    = iRst;
      up     = iUp;
      down   = iDown;
      left   = iLeft;
      right  = iRight;
      bright = iBright;
      hCount = 10'(h);
      vCount = 10'(v);
      if (modelValid) begin
         e.x    = mX;
         e.y    = mY;
         e.legs = modelLegs(mX, mY);
         e.rgb  = modelRgb(mX, mY, iBright, h, v);
         sbQ.push_back(e);
      end
      @(posedge clk);
      modelEdge(iRst, iUp, iDown, iLeft, iRight);
      #1;
   endtask

   // Hold a button pattern for n cycles while the scan position wanders,
   // often landing on or around the sprite and wall edges.
   task automatic holdButtons(input bit u, input bit d, input bit l, input bit r, input int n);
      int h;
      int v;
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 3))
            0: begin h = $urandom_range(0, 799); v = $urandom_range(0, 524); end
            1: begin h = 142 + mX + $urandom_range(0, 19); v = 33 + mY + $urandom_range(0, 19); end
            2: begin h = 140 + $urandom_range(0, 24); v = 31 + $urandom_range(0, 24); end
            default: begin h = 300 + $urandom_range(0, 340); v = 128 + $urandom_range(0, 4); end
         endcase
         applyStimulus(1'b0, u, d, l, r, ($urandom_range(0, 7) != 0), h, v);
      end
   endtask

   // Two reset cycles with every button pressed, which must have no effect.
   task automatic doReset();
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 456, 267);
   endtask

   // Monitor: pop one expectation at each falling edge and compare.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("sb_pos", {dut.r_xpos, dut.r_ypos}, {10'(e.x), 10'(e.y)});
            checkOutput("sb_legs", {leg_l, leg_r, leg_u, leg_d}, e.legs);
            checkOutput("sb_rgb", rgb, e.rgb);
            checkOutput("sb_background", background, 12'h000);
         end
      end
   end

   // Directed scenarios followed by random segments.
   initial begin
      int len;
      logic [3:0] btn;

      doReset();
      checkOutput("reset_x", dut.r_xpos, 312);
      checkOutput("reset_y", dut.r_ypos, 232);
      checkOutput("reset_legs", {leg_l, leg_r, leg_u, leg_d}, 4'b1111);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 456, 267);
      checkOutput("rgb_pacman", rgb, 12'hFF0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 144, 35);
      checkOutput("rgb_wall", rgb, 12'h00F);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 200, 300);
      checkOutput("rgb_bg", rgb, 12'h000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 456, 267);
      checkOutput("rgb_blank", rgb, 12'h000);

      doReset();
      holdButtons(1'b1, 1'b0, 1'b0, 1'b0, 100);
      checkOutput("up100_y", dut.r_ypos, 207);
      checkOutput("up100_x", dut.r_xpos, 312);
      checkOutput("up100_legs", {leg_l, leg_r, leg_u, leg_d}, 4'b1111);

      doReset();
      holdButtons(1'b1, 1'b0, 1'b0, 1'b0, 500);
      checkOutput("up500_y", dut.r_ypos, 128);
      checkOutput("up500_legs", {leg_l, leg_r, leg_u, leg_d}, 4'b1101);

      doReset();
      holdButtons(1'b0, 1'b0, 1'b1, 1'b0, 2000);
      checkOutput("left2000_x", dut.r_xpos, 16);
      checkOutput("left2000_leg_l", leg_l, 0);
      for (int k = 1; k <= 10; k++) begin
         holdButtons(1'b0, 1'b0, 1'b0, 1'b1, 4);
         checkOutput("right_step_x", dut.r_xpos, 16 + k);
      end

      doReset();
      holdButtons(1'b1, 1'b0, 1'b1, 1'b0, 40);
      checkOutput("upleft_y", dut.r_ypos, 222);
      checkOutput("upleft_x", dut.r_xpos, 312);

      holdButtons(1'b0, 1'b0, 1'b0, 1'b1, 21);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      checkOutput("midreset_x", dut.r_xpos, 312);
      checkOutput("midreset_y", dut.r_ypos, 232);

      for (int s = 0; s < 25; s++) begin
         if ($urandom_range(0, 7) == 0)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 456, 267);
         btn = 4'($urandom_range(0, 15));
         len = $urandom_range(10, 400);
         holdButtons(btn[3], btn[2], btn[1], btn[0], len);
      end

      repeat (3) @(negedge clk);
      checkOutput("sb_drain", sbQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
